// File: rtl/param_delay_line.sv
// DEPTH-stage, WIDTH-bit delay line with per-stage valid, stall, clear and a
// running occupancy count. Data registers optionally skip reset (RESET_DATA=0).
module param_delay_line #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter bit               RESET_DATA  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       d_valid,
    input  logic [WIDTH-1:0]           d,
    output logic                       q_valid,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] w_vld_in;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;

    if (DEPTH > 1) begin : g_vld_multi
        assign w_vld_in = {r_vld[DEPTH-2:0], d_valid};
    end else begin : g_vld_single
        assign w_vld_in = d_valid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
        end else if (clr) begin
            r_vld <= '0;
        end else if (en) begin
            r_vld <= w_vld_in;
        end
    end

    // Modular add/sub is exact because the true result always lies in 0..DEPTH.
    assign w_count_next = r_count + CW'(d_valid) - CW'(r_vld[DEPTH-1]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_count_next;
        end
    end

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] r_data;
        logic [WIDTH-1:0] w_in;

        if (gi == 0) begin : g_head
            assign w_in = d;
        end else begin : g_tail
            assign w_in = g_stage[gi-1].r_data;
        end

        if (RESET_DATA) begin : g_rst
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_data <= RESET_VALUE;
                end else if (clr) begin
                    r_data <= RESET_VALUE;
                end else if (en) begin
                    r_data <= w_in;
                end
            end
        end else begin : g_norst
            // No reset term keeps these as plain enable flops; contents survive clr.
            always_ff @(posedge clk) begin
                if (en && !clr) begin
                    r_data <= w_in;
                end
            end
        end
    end

    assign q       = g_stage[DEPTH-1].r_data;
    assign q_valid = r_vld[DEPTH-1];
    assign count   = r_count;

endmodule

// File: tb/tb_param_delay_line.sv
// Self-checking bench: a queue scoreboard models pipeline contents and is
// compared against two instances (data reset on / off) after every edge.
module tb_param_delay_line;
    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam int         CW    = $clog2(DEPTH+1);
    localparam logic [7:0] RV    = 8'hA5;

    logic             clk;
    logic             rstn;
    logic             en;
    logic             clr;
    logic             d_valid;
    logic [WIDTH-1:0] d;
    logic             qv_a, qv_b;
    logic [WIDTH-1:0] q_a, q_b;
    logic [CW-1:0]    cnt_a, cnt_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
    } ent_t;
    ent_t pipe[$];

    param_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(1'b1), .RESET_VALUE(RV)) dut_a (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d_valid(d_valid), .d(d),
        .q_valid(qv_a), .q(q_a), .count(cnt_a)
    );

    param_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(1'b0), .RESET_VALUE(RV)) dut_b (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d_valid(d_valid), .d(d),
        .q_valid(qv_b), .q(q_b), .count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        ent_t e;
        e.v = 1'b0;
        e.d = RV;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    endfunction

    function automatic int model_count();
        int n = 0;
        foreach (pipe[i]) if (pipe[i].v) n++;
        return n;
    endfunction

    // One clock: drive inputs, update the scoreboard, then compare both DUTs.
    task automatic step(input logic e_i, input logic c_i, input logic dv_i, input logic [WIDTH-1:0] d_i);
        ent_t e;
        en = e_i; clr = c_i; d_valid = dv_i; d = d_i;
        @(posedge clk);
        if (c_i) begin
            model_reset();
        end else if (e_i) begin
            e.v = dv_i;
            e.d = d_i;
            pipe.push_back(e);
            void'(pipe.pop_front());
        end
        #1;
        total++;
        if (qv_a !== pipe[0].v) begin
            bad++; $display("FAIL sb_qv_a: got %b want %b", qv_a, pipe[0].v);
        end
        total++;
        if (q_a !== pipe[0].d) begin
            bad++; $display("FAIL sb_q_a: got %0h want %0h", q_a, pipe[0].d);
        end
        total++;
        if (cnt_a !== CW'(model_count())) begin
            bad++; $display("FAIL sb_cnt_a: got %0d want %0d", cnt_a, model_count());
        end
        total++;
        if (qv_b !== pipe[0].v) begin
            bad++; $display("FAIL sb_qv_b: got %b want %b", qv_b, pipe[0].v);
        end
        total++;
        if (cnt_b !== CW'(model_count())) begin
            bad++; $display("FAIL sb_cnt_b: got %0d want %0d", cnt_b, model_count());
        end
        if (pipe[0].v) begin
            total++;
            if (q_b !== pipe[0].d) begin
                bad++; $display("FAIL sb_q_b: got %0h want %0h", q_b, pipe[0].d);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1; en = 1'b0; clr = 1'b0; d_valid = 1'b0; d = '0;
        #1 rstn = 1'b0;
        #1;
        total++;
        if (q_a !== RV) begin bad++; $display("FAIL reset_q: got %0h want %0h", q_a, RV); end
        total++;
        if (qv_a !== 1'b0 || qv_b !== 1'b0) begin
            bad++; $display("FAIL reset_qv: got %b/%b want 0/0", qv_a, qv_b);
        end
        total++;
        if (cnt_a !== '0 || cnt_b !== '0) begin
            bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cnt_a, cnt_b);
        end
        model_reset();
        #6 rstn = 1'b1;
        $display("reset: q=%0h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b1, WIDTH'(i));
            total++;
            if (cnt_a !== CW'((i < DEPTH) ? i : DEPTH)) begin
                bad++; $display("FAIL stream_cnt: got %0d want %0d", cnt_a, (i < DEPTH) ? i : DEPTH);
            end
            if (i >= DEPTH) begin
                total++;
                if (q_a !== WIDTH'(i - DEPTH + 1) || qv_a !== 1'b1) begin
                    bad++; $display("FAIL stream_q: got %0h/%b want %0h/1", q_a, qv_a, i - DEPTH + 1);
                end
            end
            $display("stream: in=%0d q=%0h qv=%b cnt=%0d", i, q_a, qv_a, cnt_a);
        end
    endtask

    task automatic test_stall();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, WIDTH'(i));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'hEE);
            total++;
            if (q_a !== 8'd1 || cnt_a !== CW'(4)) begin
                bad++; $display("FAIL stall_hold: got q=%0h cnt=%0d want q=1 cnt=4", q_a, cnt_a);
            end
            $display("stall: q=%0h cnt=%0d", q_a, cnt_a);
        end
        step(1'b1, 1'b0, 1'b1, 8'd9);
        total++;
        if (q_a !== 8'd2) begin bad++; $display("FAIL stall_resume: got %0h want 2", q_a); end
        $display("stall resume: q=%0h", q_a);
    endtask

    task automatic test_bubbles();
        logic [3:0] dv_pat;
        logic [7:0] exp_q [4];
        int peak;
        dv_pat = 4'b1101;
        exp_q[0] = 8'd10; exp_q[1] = 8'd11; exp_q[2] = 8'd12; exp_q[3] = 8'd13;
        peak = 0;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, dv_pat[i], exp_q[i]);
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (qv_a !== dv_pat[i]) begin
                bad++; $display("FAIL bubble_qv%0d: got %b want %b", i, qv_a, dv_pat[i]);
            end
            if (dv_pat[i]) begin
                total++;
                if (q_a !== exp_q[i]) begin
                    bad++; $display("FAIL bubble_q%0d: got %0h want %0h", i, q_a, exp_q[i]);
                end
            end
            $display("bubble: q=%0h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
            step(1'b1, 1'b0, 1'b0, 8'h00);
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
        end
        total++;
        if (peak != 3) begin bad++; $display("FAIL bubble_peak: got %0d want 3", peak); end
    endtask

    task automatic test_clear();
        bit seen;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, WIDTH'(20 + i));
        total++;
        if (cnt_a !== CW'(3)) begin bad++; $display("FAIL clear_pre: got %0d want 3", cnt_a); end
        step(1'b1, 1'b1, 1'b1, 8'd99);
        total++;
        if (cnt_a !== '0 || qv_a !== 1'b0 || cnt_b !== '0) begin
            bad++; $display("FAIL clear_now: got cnt=%0d/%0d qv=%b want 0/0/0", cnt_a, cnt_b, qv_a);
        end
        $display("clear: q=%0h qv=%b cnt=%0d", q_a, qv_a, cnt_a);
        seen = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            if (qv_a !== 1'b0 || qv_b !== 1'b0 || q_a === 8'd99) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL clear_drop: got reappear=1 want 0"); end
    endtask

    task automatic test_mid_reset();
        step(1'b1, 1'b0, 1'b1, 8'd30);
        step(1'b1, 1'b0, 1'b1, 8'd31);
        rstn = 1'b0;
        #1;
        total++;
        if (qv_b !== 1'b0 || cnt_b !== '0 || qv_a !== 1'b0 || cnt_a !== '0) begin
            bad++; $display("FAIL midrst: got qv=%b cnt=%0d want 0/0", qv_b, cnt_b);
        end
        model_reset();
        #2 rstn = 1'b1;
        $display("mid reset: qv=%b cnt=%0d", qv_b, cnt_b);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, WIDTH'(40 + i));
        total++;
        if (q_b !== 8'd40 || qv_b !== 1'b1) begin
            bad++; $display("FAIL midrst_refill: got %0h/%b want 28/1", q_b, qv_b);
        end
        $display("refill: q=%0h qv=%b cnt=%0d", q_b, qv_b, cnt_b);
    endtask

    task automatic test_x_data();
        step(1'b1, 1'b0, 1'b0, 'x);
        step(1'b1, 1'b0, 1'b1, 8'd50);
        total++;
        if ($isunknown(cnt_a) || $isunknown(cnt_b)) begin
            bad++; $display("FAIL x_cnt: got %0d/%0d want known", cnt_a, cnt_b);
        end
        $display("xdata: cnt=%0d", cnt_a);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubbles();
        test_clear();
        test_mid_reset();
        test_x_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
